// File: rtl/i2c_resp_pkg.sv
// Shared types and bus constants for the I2C target responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    WR_DATA,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_responder_line_sync.sv
// Synchronizes SCL/SDA into clk and decodes SCL edges plus START/STOP.
// Latency: pin change appears as an event 2 clk later, acted on at the 3rd edge.
// Backpressure: none; events are single-cycle pulses and must be consumed.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_q1, scl_q2, scl_q3;
  logic sda_q1, sda_q2, sda_q3;

  // Two-flop synchronizer plus one history stage; reset to the idle-bus level
  // so leaving reset never fabricates an edge or bus condition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_q1 <= 1'b1;
      scl_q2 <= 1'b1;
      scl_q3 <= 1'b1;
      sda_q1 <= 1'b1;
      sda_q2 <= 1'b1;
      sda_q3 <= 1'b1;
    end else begin
      scl_q1 <= scl_i;
      scl_q2 <= scl_q1;
      scl_q3 <= scl_q2;
      sda_q1 <= sda_i;
      sda_q2 <= sda_q1;
      sda_q3 <= sda_q2;
    end
  end

  assign scl_rise  =  scl_q2 & ~scl_q3;
  assign scl_fall  = ~scl_q2 &  scl_q3;
  // SDA moving while SCL is stably high is a bus condition, not data.
  assign start_det =  scl_q2 & scl_q3 &  sda_q3 & ~sda_q2;
  assign stop_det  =  scl_q2 & scl_q3 & ~sda_q3 &  sda_q2;
  assign sda_s     =  sda_q2;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target serving a DEPTH-byte register file with an auto-incrementing pointer.
// Latency: bus events act 3 clk after the pin edge; SDA drive changes only on SCL fall.
// Backpressure: never stretches SCL; rx_valid is a one-cycle pulse with no ready.
module i2c_target_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  localparam int        PW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          sda_t,
  output logic          busy,
  output logic          rx_valid,
  output logic [PW-1:0] rx_ptr,
  output logic [7:0]    rx_data
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic          rw, rw_nxt;
  logic          sda_t_nxt, busy_nxt, rx_valid_nxt;
  logic [PW-1:0] rx_ptr_nxt;
  logic [7:0]    rx_data_nxt;
  logic          mem_we;
  logic [7:0]    mem [DEPTH];

  logic [7:0]    rx_byte;
  logic [PW-1:0] ptr_inc;
  logic [7:0]    rd_cur, rd_inc;

  assign sda_o   = 1'b0;
  assign rx_byte = {shreg[6:0], sda_s};
  assign ptr_inc = ptr + 1'b1;   // DEPTH is a power of two, so this wraps
  assign rd_cur  = mem[ptr];
  assign rd_inc  = mem[ptr_inc];

  // Next-state and output decode; STOP outranks START, which outranks bit work.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    ptr_nxt      = ptr;
    rw_nxt       = rw;
    sda_t_nxt    = sda_t;
    busy_nxt     = busy;
    rx_valid_nxt = 1'b0;
    rx_ptr_nxt   = rx_ptr;
    rx_data_nxt  = rx_data;
    mem_we       = 1'b0;
    if (stop_det) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
      sda_t_nxt = 1'b1;
      busy_nxt  = 1'b0;
    end else if (start_det) begin
      state_nxt = ADDR;
      cnt_nxt   = 4'd0;
      sda_t_nxt = 1'b1;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shreg_nxt = rx_byte;
            cnt_nxt   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_nxt = 4'd0;
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_nxt = ADDR_ACK;
                busy_nxt  = 1'b1;
                rw_nxt    = rx_byte[0];
              end else begin
                state_nxt = IGNORE;
              end
            end
          end
        end
        // First fall pulls SDA low; the following fall ends the ACK clock.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (sda_t) begin
              sda_t_nxt = ACK;
            end else if (rw == RW_READ) begin
              shreg_nxt = rd_cur;
              sda_t_nxt = rd_cur[7];
              cnt_nxt   = 4'd0;
              state_nxt = RD_DATA;
            end else begin
              sda_t_nxt = 1'b1;
              cnt_nxt   = 4'd0;
              state_nxt = WR_PTR;
            end
          end
        end
        // cnt==8 is the ACK clock of the byte just received.
        WR_PTR, WR_DATA: begin
          if (cnt == 4'd8) begin
            if (scl_fall) begin
              if (sda_t) begin
                sda_t_nxt = ACK;
              end else begin
                sda_t_nxt = 1'b1;
                cnt_nxt   = 4'd0;
                state_nxt = WR_DATA;
              end
            end
          end else if (scl_rise) begin
            shreg_nxt = rx_byte;
            cnt_nxt   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (state == WR_PTR) begin
                ptr_nxt = rx_byte[PW-1:0];
              end else begin
                mem_we       = 1'b1;
                rx_valid_nxt = 1'b1;
                rx_ptr_nxt   = ptr;
                rx_data_nxt  = rx_byte;
                ptr_nxt      = ptr_inc;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt == 4'd7) begin
              sda_t_nxt = 1'b1;
              cnt_nxt   = 4'd0;
              state_nxt = RD_ACK;
            end else begin
              cnt_nxt   = cnt + 4'd1;
              shreg_nxt = {shreg[6:0], 1'b0};
              sda_t_nxt = shreg[6];
            end
          end
        end
        // cnt==0: waiting for the master's ACK bit; cnt==1: ACKed, drive MSB on fall.
        RD_ACK: begin
          if (cnt == 4'd0) begin
            if (scl_rise) begin
              ptr_nxt = ptr_inc;
              if (sda_s == ACK) begin
                shreg_nxt = rd_inc;
                cnt_nxt   = 4'd1;
              end else begin
                state_nxt = IGNORE;
              end
            end
          end else if (scl_fall) begin
            sda_t_nxt = shreg[7];
            cnt_nxt   = 4'd0;
            state_nxt = RD_DATA;
          end
        end
        IGNORE:  sda_t_nxt = 1'b1;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      shreg    <= 8'd0;
      ptr      <= '0;
      rw       <= RW_WRITE;
      sda_t    <= 1'b1;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_ptr   <= '0;
      rx_data  <= 8'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shreg    <= shreg_nxt;
      ptr      <= ptr_nxt;
      rw       <= rw_nxt;
      sda_t    <= sda_t_nxt;
      busy     <= busy_nxt;
      rx_valid <= rx_valid_nxt;
      rx_ptr   <= rx_ptr_nxt;
      rx_data  <= rx_data_nxt;
    end
  end

  // Register file: cleared by reset, written in the same clk as rx_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
    end else if (mem_we) begin
      mem[ptr] <= rx_byte;
    end
  end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
Synthesizable I2C target (slave) that answers the bridge's I2C master on the same open-drain bus.
- Watches the resolved SCL/SDA lines and decodes START, STOP and repeated START.
- Matches a 7-bit address, ACKs, and serves a DEPTH-byte register file with an auto-incrementing pointer.
- Serves as the RTL responder in bridge loopback benches and as a reference target for the slave agent.

Parameters:
- SLAVE_ADDR, 7'h50: 7-bit target address.
- DEPTH, 16: register file bytes; power of two, 2..256.
- PW, $clog2(DEPTH): pointer width (derived, not overridable).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- scl_i  input  1  resolved bus SCL (asynchronous to clk).
- sda_i  input  1  resolved bus SDA (asynchronous to clk).
- sda_o  output  1  SDA drive value; constant 0.
- sda_t  output  1  SDA tristate; 1 = release, 0 = pull low.
- busy  output  1  high from address match until STOP or repeated START.
- rx_valid  output  1  one-cycle pulse, data byte written to register file.
- rx_ptr  output  PW  register index of the rx_valid byte.
- rx_data  output  8  byte written.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - sda_t=1, busy=0, rx_valid=0, rx_ptr=0, rx_data=0.
  - Pointer = 0, register file cleared to 0, state = IDLE.
  - Reset mid-transfer releases SDA on the next clk edge.
- Input sampling:
  - 2-FF synchronizer on scl_i/sda_i, plus a third register for edge detect.
  - Pin-to-event latency is 3 clk cycles.
- Bus conditions:
  - START = SDA fall while SCL high; STOP = SDA rise while SCL high.
  - START in any state goes to ADDR with bit count 0. Pointer is kept, so a repeated START can follow a pointer write.
  - STOP in any state goes to IDLE, releases SDA and clears busy.
  - STOP wins over bit processing in the same cycle.
- Bit timing:
  - Data is sampled MSB first on the synchronized SCL rise.
  - sda_t changes only on the synchronized SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If addr[7:1]==SLAVE_ADDR go to ADDR_ACK and set busy; else go to IGNORE.
  - ADDR_ACK: pull SDA low for one SCL clock. Then R/W=0 goes to WR_PTR; R/W=1 loads shift register with mem[ptr] and goes to RD_DATA.
  - WR_PTR: 8 bits; ptr <= byte[PW-1:0] (upper bits dropped); ACK, then WR_DATA.
  - WR_DATA: 8 bits; mem[ptr] <= byte; rx_valid pulse with pre-increment ptr; ptr <= ptr+1 mod DEPTH; ACK, then WR_DATA.
  - RD_DATA: drive shift register MSB first (sda_t = bit); release SDA after the 8th SCL fall, then go to RD_ACK.
  - RD_ACK: sample master bit on SCL rise. ACK(0) gives ptr+1 mod DEPTH, reloads shift register, back to RD_DATA. NACK(1) gives ptr+1, then IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer wraps DEPTH-1 -> 0 on both read and write.
- The target never stretches SCL; there is no SCL output.
- Write/read collision: rx_valid and register write happen in the same clk. A read byte is captured at load time and is never affected by later writes.

Decomposition:
- Package i2c_resp_pkg holds the state enum (IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, RD_DATA, RD_ACK, IGNORE), the ACK=1'b0 / NACK=1'b1 constants and the RW_WRITE/RW_READ constants.
- Sub-module i2c_line_sync holds the synchronizers and edge detect. Its outputs are scl_rise, scl_fall, start_det, stop_det and sda_s.

Test Plan:
- Write: START, 0xA0, ptr 0x03, data 0x5A, 0xC3, STOP -> ACK on all 4 bytes; rx_valid twice with (ptr 3, 0x5A) then (ptr 4, 0xC3); mem[3]=0x5A, mem[4]=0xC3; busy low after STOP.
- Read: after the write test, START, 0xA0, ptr 0x03, Sr, 0xA1, read 2 bytes (ACK, NACK), STOP -> target returns 0x5A then 0xC3; SDA released after NACK.
- Wrap: write ptr 0x0F with data 0x11, 0x22 (DEPTH=16) -> mem[15]=0x11, mem[0]=0x22; pointer byte 0x13 selects index 3.
- Address mismatch: START, 0xA2, 0xFF, STOP -> sda_t stays 1 throughout, busy stays 0, no rx_valid.
- Abort: STOP injected after 4 data bits of a write -> no rx_valid, state IDLE, sda_t=1. Then rst_n low while driving a read-data 0 bit -> sda_t=1 on the next clk edge.
- Timing: single SCL rise -> sample taken exactly 3 clk after the pin edge; ACK pull-down asserts within 3 clk of the 8th SCL fall.
